// File: rtl/ddr5_ca_cmd_scheduler.sv
// Two-port round-robin CA command scheduler: arbitrates host/training requests and
// drives 1- or 2-cycle DDR5 commands onto the registered CA bus with a deselect gap.
module ddr5_ca_cmd_scheduler #(
    parameter int unsigned CA_W       = 14,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                dfi_phy_clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid_i,
    output logic [1:0]          req_ready_o,
    input  logic [2*CA_W-1:0]   req_ca0_i,
    input  logic [2*CA_W-1:0]   req_ca1_i,
    input  logic [1:0]          req_two_cyc_i,
    output logic                grant_id_o,
    output logic                cmd_done_o,
    output logic                busy_o,
    output logic [CA_W-1:0]     CA_DA_o,
    output logic                CS_DA_o,
    output logic                CA_VALID_DA_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD1,
        ST_CMD2,
        ST_GAP
    } state_t;

    localparam state_t     ST_AFTER = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t            state_q;
    state_t            state_d;
    logic              rr_pref_q;
    logic [3:0]        gap_cnt_q;
    logic [CA_W-1:0]   ca1_q;
    logic              two_cyc_q;

    logic [1:0]        grant;
    logic              accept;
    logic              win_id;
    logic [CA_W-1:0]   win_ca0;
    logic [CA_W-1:0]   win_ca1;

    logic [CA_W-1:0]   ca_d;
    logic              cs_d;
    logic              vld_d;
    logic              done_d;

    // Grant is only offered in IDLE; a lone requester wins regardless of preference.
    always_comb begin
        grant = '0;
        if (state_q == ST_IDLE) begin
            if (req_valid_i == 2'b11) begin
                grant = rr_pref_q ? 2'b10 : 2'b01;
            end else begin
                grant = req_valid_i;
            end
        end
    end

    assign req_ready_o = grant;
    assign accept      = |grant;
    assign win_id      = grant[1];
    assign win_ca0     = win_id ? req_ca0_i[CA_W +: CA_W] : req_ca0_i[0 +: CA_W];
    assign win_ca1     = win_id ? req_ca1_i[CA_W +: CA_W] : req_ca1_i[0 +: CA_W];
    assign busy_o      = (state_q != ST_IDLE);

    // Bus values are computed for the next state so every bus output is a flop.
    always_comb begin
        state_d = state_q;
        ca_d    = '0;
        cs_d    = 1'b1;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_CMD1;
                    ca_d    = win_ca0;
                    cs_d    = 1'b0;
                    vld_d   = 1'b1;
                    done_d  = ~req_two_cyc_i[win_id];
                end
            end
            ST_CMD1: begin
                if (two_cyc_q) begin
                    state_d = ST_CMD2;
                    ca_d    = ca1_q;
                    vld_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_AFTER;
                end
            end
            ST_CMD2: begin
                state_d = ST_AFTER;
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge dfi_phy_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rr_pref_q     <= 1'b0;
            gap_cnt_q     <= '0;
            ca1_q         <= '0;
            two_cyc_q     <= 1'b0;
            grant_id_o    <= 1'b0;
            CA_DA_o       <= '0;
            CS_DA_o       <= 1'b1;
            CA_VALID_DA_o <= 1'b0;
            cmd_done_o    <= 1'b0;
        end else begin
            state_q       <= state_d;
            CA_DA_o       <= ca_d;
            CS_DA_o       <= cs_d;
            CA_VALID_DA_o <= vld_d;
            cmd_done_o    <= done_d;
            if (accept) begin
                rr_pref_q  <= ~win_id;
                grant_id_o <= win_id;
                two_cyc_q  <= req_two_cyc_i[win_id];
                ca1_q      <= win_ca1;
            end
            if ((state_d == ST_GAP) && (state_q != ST_GAP)) begin
                gap_cnt_q <= GAP_LOAD;
            end else if ((state_q == ST_GAP) && (gap_cnt_q != '0)) begin
                gap_cnt_q <= gap_cnt_q - 4'd1;
            end
        end
    end

endmodule
